// File: rtl/fifo_pkg.sv
// Shared helpers for the Gray-pointer async FIFO: pointer code conversion
// and width helpers used by both the write-side and read-side blocks.
package fifo_pkg;

  // Conversions run on a wide word; callers zero-extend their pointer in
  // and truncate the result back to pointer width. Gray<->binary on a
  // zero-extended value leaves the low bits identical to a narrow conversion.
  localparam int CONV_W = 32;

  typedef logic [CONV_W-1:0] conv_word_t;

  // Pointer width for a given address width: one extra bit distinguishes
  // a full FIFO from an empty one when the addresses match.
  function automatic int ptr_width(input int addrW);
    return addrW + 1;
  endfunction

  // Binary to reflected Gray code.
  function automatic conv_word_t bin2gray(input conv_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary, folding XORs down from the MSB.
  function automatic conv_word_t gray2bin(input conv_word_t gray);
    conv_word_t bin;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Binary/Gray pointer counter shared by the write and read pointer blocks.
// Exposes both the registered pointers and the combinational next values so
// the owner can compare against the far-side pointer one edge early.
module gray_counter
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_bin,
  output logic [W-1:0] o_binNext,
  output logic [W-1:0] o_gray,
  output logic [W-1:0] o_grayNext
);

  logic [W-1:0] binQ;
  logic [W-1:0] grayQ;

  // Next values: the binary count wraps naturally modulo 2**W, and the
  // Gray code of the wrapped value differs from the current one in one bit.
  assign o_binNext  = binQ + W'(i_inc);
  assign o_grayNext = W'(bin2gray(CONV_W'(o_binNext)));

  // Both codes are registered so the Gray output toggles cleanly off a flop,
  // which is what makes it safe to hand to another clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      binQ  <= '0;
      grayQ <= '0;
    end else begin
      binQ  <= o_binNext;
      grayQ <= o_grayNext;
    end
  end

  assign o_bin  = binQ;
  assign o_gray = grayQ;

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer and status block for the dual-clock async FIFO.
// Advances the write pointer on accepted writes, produces the Gray pointer
// that crosses to the read side, and derives full / level / almost-full /
// sticky overflow from the synchronised read pointer.
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter bit AF_DISABLE_ZERO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic [ADDR_W:0]   i_readPtr,
  input  logic [ADDR_W:0]   i_afThresh,
  input  logic              i_clrOverflow,
  output logic [ADDR_W:0]   o_writePtr,
  output logic [ADDR_W-1:0] o_writeAddr,
  output logic              o_writeEn,
  output logic              o_full,
  output logic              o_almostFull,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow
);

  localparam int PTR_W = ptr_width(ADDR_W);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic             writeAccept;
  logic [PTR_W-1:0] binQ;
  logic [PTR_W-1:0] binNext;
  logic [PTR_W-1:0] grayQ;
  logic [PTR_W-1:0] grayNext;
  logic [PTR_W-1:0] readGrayFull;
  logic [PTR_W-1:0] readBin;
  logic [PTR_W-1:0] levelNext;
  logic             fullNext;
  logic             afNext;
  logic             overflowNext;

  logic [PTR_W-1:0] levelQ;
  logic             fullQ;
  logic             afQ;
  logic             overflowQ;

  // A write only lands when there is room and we are not in reset; this is
  // also the memory write strobe, so a dropped write never touches the RAM.
  assign writeAccept = i_inc & ~fullQ & ~i_rst;

  gray_counter #(
    .W(PTR_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (writeAccept),
    .o_bin      (binQ),
    .o_binNext  (binNext),
    .o_gray     (grayQ),
    .o_grayNext (grayNext)
  );

  // Full means the write pointer is exactly one lap ahead of the read
  // pointer; in Gray code that is the read pointer with its top two bits
  // inverted.
  assign readGrayFull = {~i_readPtr[ADDR_W:ADDR_W-1], i_readPtr[ADDR_W-2:0]};
  assign fullNext     = (grayNext == readGrayFull);

  // Occupancy uses modulo pointer arithmetic; it reaches DEPTH exactly when
  // full and is pessimistic because the read pointer is a few clocks stale.
  assign readBin   = PTR_W'(gray2bin(CONV_W'(i_readPtr)));
  assign levelNext = binNext - readBin;

  // Almost-full compare: zero threshold is either a disable or a force-on
  // depending on the build, and thresholds above DEPTH can never be reached.
  always_comb begin
    afNext = 1'b0;
    if (i_afThresh == '0) begin
      afNext = ~AF_DISABLE_ZERO;
    end else if (i_afThresh > DEPTH_P) begin
      afNext = 1'b0;
    end else begin
      afNext = (levelNext >= i_afThresh);
    end
  end

  // Sticky overflow: a write attempted while full sets it, and the set
  // takes priority over a clear arriving in the same cycle.
  always_comb begin
    overflowNext = overflowQ;
    if (i_clrOverflow) begin
      overflowNext = 1'b0;
    end
    if (i_inc && fullQ) begin
      overflowNext = 1'b1;
    end
  end

  // Status registers: everything reflects an accepted write right after the
  // edge that accepted it, and reset wipes all of it in one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      levelQ    <= '0;
      fullQ     <= 1'b0;
      afQ       <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      levelQ    <= levelNext;
      fullQ     <= fullNext;
      afQ       <= afNext;
      overflowQ <= overflowNext;
    end
  end

  assign o_writePtr   = grayQ;
  assign o_writeAddr  = ADDR_W'(binQ);
  assign o_writeEn    = writeAccept;
  assign o_full       = fullQ;
  assign o_almostFull = afQ;
  assign o_level      = levelQ;
  assign o_overflow   = overflowQ;

endmodule

// File: tb/tb_wptr_full_level.sv
// Self-checking bench for wptr_full_level (ADDR_W=4). Two instances share
// stimulus: dutA disables almost-full at threshold 0, dutB forces it on.
module tb_wptr_full_level;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc;
  logic       clr;
  logic [4:0] readPtr;
  logic [4:0] afThresh;

  logic [4:0] aWritePtr, bWritePtr;
  logic [3:0] aWriteAddr, bWriteAddr;
  logic       aWriteEn, bWriteEn;
  logic       aFull, bFull;
  logic       aAf, bAf;
  logic [4:0] aLevel, bLevel;
  logic       aOvf, bOvf;

  wptr_full_level #(.ADDR_W(ADDR_W), .AF_DISABLE_ZERO(1'b1)) dutA (
    .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_readPtr(readPtr),
    .i_afThresh(afThresh), .i_clrOverflow(clr),
    .o_writePtr(aWritePtr), .o_writeAddr(aWriteAddr), .o_writeEn(aWriteEn),
    .o_full(aFull), .o_almostFull(aAf), .o_level(aLevel), .o_overflow(aOvf)
  );

  wptr_full_level #(.ADDR_W(ADDR_W), .AF_DISABLE_ZERO(1'b0)) dutB (
    .i_clk(clk), .i_rst(rst), .i_inc(inc), .i_readPtr(readPtr),
    .i_afThresh(afThresh), .i_clrOverflow(clr),
    .o_writePtr(bWritePtr), .o_writeAddr(bWriteAddr), .o_writeEn(bWriteEn),
    .o_full(bFull), .o_almostFull(bAf), .o_level(bLevel), .o_overflow(bOvf)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: total accepted writes and read count as plain integers.
  int mWr   = 0;
  int mLevel = 0;
  bit mFull = 0;
  bit mAfA  = 0;
  bit mAfB  = 0;
  bit mOvf  = 0;
  int rdCount = 0;

  typedef struct {
    bit inc;
    int rd;
    int thresh;
    int expLevel;
    bit expFull;
    bit expAf;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [4:0] toGray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare every registered output of both instances against the model.
  task automatic checkOutput();
    compare("writePtr",  aWritePtr, toGray(mWr));
    compare("writeAddr", aWriteAddr, mWr % DEPTH);
    compare("level",     aLevel, mLevel);
    compare("full",      aFull, mFull);
    compare("afA",       aAf, mAfA);
    compare("overflow",  aOvf, mOvf);
    compare("afB",       bAf, mAfB);
    compare("levelB",    bLevel, mLevel);
  endtask

  // Drive one cycle of inputs, check the write strobe mid-cycle, clock it,
  // advance the model, then check all outputs just after the edge.
  task automatic applyStimulus(input bit vInc, input int vRd, input int vThresh,
                               input bit vClr, input bit vRst);
    bit accept;
    inc      = vInc;
    readPtr  = toGray(vRd);
    afThresh = 5'(vThresh);
    clr      = vClr;
    rst      = vRst;
    @(negedge clk);
    accept = vInc && !mFull && !vRst;
    compare("writeEn", aWriteEn, accept);
    compare("writeEnB", bWriteEn, accept);
    @(posedge clk);
    if (vRst) begin
      mWr = 0; mLevel = 0; mFull = 0; mAfA = 0; mAfB = 0; mOvf = 0;
    end else begin
      if (vInc && mFull) mOvf = 1;
      else if (vClr) mOvf = 0;
      if (accept) mWr++;
      mLevel = mWr - vRd;
      mFull  = (mLevel == DEPTH);
      mAfA   = (vThresh == 0) ? 1'b0 : (vThresh <= DEPTH && mLevel >= vThresh);
      mAfB   = (vThresh == 0) ? 1'b1 : (vThresh <= DEPTH && mLevel >= vThresh);
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int vThresh);
    rdCount = 0;
    applyStimulus(0, 0, vThresh, 0, 1);
    applyStimulus(0, 0, vThresh, 0, 1);
  endtask

  initial begin
    logic [4:0] prevPtr;
    int thresh;
    bit rInc, rClr, rRst;

    rst = 1; inc = 0; clr = 0; readPtr = '0; afThresh = 5'd12;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{inc: 1'b1, rd: 0, thresh: 12, expLevel: i + 1,
                  expFull: (i == 15), expAf: (i + 1 >= 12)};
    end

    // Reset state
    doReset(12);
    compare("rstPtr", aWritePtr, 0);
    compare("rstLevel", aLevel, 0);

    // Fill to full from the vector table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].inc, vecs[i].rd, vecs[i].thresh, 1'b0, 1'b0);
      compare("vecLevel", aLevel, vecs[i].expLevel);
      compare("vecFull", aFull, vecs[i].expFull);
      compare("vecAf", aAf, vecs[i].expAf);
    end
    compare("fullPtr", aWritePtr, 5'b11000);
    compare("fullAddr", aWriteAddr, 0);

    // Writes while full are dropped and flag overflow
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 12, 0, 0);
      compare("ovfSet", aOvf, 1);
      compare("ovfPtrFrozen", aWritePtr, 5'b11000);
    end
    applyStimulus(0, 0, 12, 1, 0);
    compare("ovfClr", aOvf, 0);
    applyStimulus(1, 0, 12, 1, 0);
    compare("ovfSetWins", aOvf, 1);
    applyStimulus(0, 0, 12, 1, 0);
    compare("ovfClr2", aOvf, 0);
    applyStimulus(0, 0, 17, 0, 0);
    compare("thr17A", aAf, 0);
    compare("thr17B", bAf, 0);

    // Almost-full rising edge and read-side release
    doReset(12);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 0, 12, 0, 0);
      compare("afRise", aAf, (i >= 12));
    end
    applyStimulus(0, 2, 12, 0, 0);
    compare("afLevel10", aLevel, 10);
    compare("afFall", aAf, 0);

    // Reset mid-stream with a concurrent write
    doReset(12);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 12, 0, 0);
    compare("midLevel9", aLevel, 9);
    applyStimulus(1, 0, 12, 0, 1);
    compare("midRstLevel", aLevel, 0);
    compare("midRstPtr", aWritePtr, 0);
    compare("midRstAddr", aWriteAddr, 0);

    // Threshold zero: disabled on A, forced on B
    doReset(0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      compare("thr0A", aAf, 0);
      compare("thr0B", bAf, 1);
    end

    // Streaming with the read pointer one behind, across the pointer wrap
    doReset(12);
    prevPtr = aWritePtr;
    for (int i = 0; i < 40; i++) begin
      rdCount = (mWr > 0) ? mWr - 1 : 0;
      applyStimulus(1, rdCount, 12, 0, 0);
      compare("grayOneBit", $countones(aWritePtr ^ prevPtr), 1);
      compare("streamNotFull", aFull, 0);
      prevPtr = aWritePtr;
    end

    // Randomised traffic against the model
    doReset(8);
    thresh = 8;
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) thresh = int'($urandom_range(0, 20));
      rInc = ($urandom % 4) != 0;
      rClr = ($urandom % 8) == 0;
      rRst = ($urandom % 100) == 0;
      if (rRst) begin
        rdCount = 0;
      end else if (($urandom % 3) == 0 && rdCount < mWr) begin
        rdCount = rdCount + 1;
      end
      applyStimulus(rInc, rdCount, thresh, rClr, rRst);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
